// File: rtl/game_ctrl_pkg.sv
// Shared constants for the crossy-road game sequencer and its consumers.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package game_ctrl_pkg;

  // Game state encoding, also decoded by the renderer
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  // Default timing at a 25 MHz pixel clock
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_HIT_FRAMES      = 60;
  localparam int DEF_OVER_FRAMES     = 30;
  localparam int DEF_LIVES           = 3;

  // Frame counter width: at least 6 bits so bit 3 drives the hit flash,
  // wider only when the longer frame interval needs it.
  function automatic int frame_cnt_w(input int hit_frames, input int over_frames);
    int max_frames;
    int w;
    max_frames = (hit_frames > over_frames) ? hit_frames : over_frames;
    w = $clog2(max_frames + 1);
    return (w < 6) ? 6 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a stable raw edge to btn_db/btn_rise.
// Backpressure: none; btn_rise is a single-cycle pulse with no handshake.
module btn_debounce
  import game_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that disagree with btn_db; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      btn_db     <= 1'b0;
      btn_rise   <= 1'b0;
    end else if (sync_q2 == btn_db) begin
      stable_cnt <= '0;
      btn_rise   <= 1'b0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      btn_db     <= sync_q2;
      btn_rise   <= sync_q2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
      btn_rise   <= 1'b0;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer (IDLE/RUN/HIT/OVER) gating the scroll datapath; optional lives via GAME_CTRL_LIVES_EN.
// Latency: all outputs registered, one cycle after the causing input is sampled.
// Backpressure: none; collision wins over every other event while in RUN.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HIT_FRAMES      = DEF_HIT_FRAMES,
  parameter int OVER_FRAMES     = DEF_OVER_FRAMES,
  parameter int LIVES           = DEF_LIVES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  input  logic       collision,
  input  logic       frame_tick,
  output logic       scroll_en,
  output logic       scroll_reset,
  output logic [1:0] state,
  output logic       game_over,
  output logic       flash,
  output logic [1:0] lives
);

  localparam int FW = frame_cnt_w(HIT_FRAMES, OVER_FRAMES);
  localparam logic [FW-1:0] HIT_LAST = FW'(HIT_FRAMES - 1);
  localparam logic [FW-1:0] OVER_SAT = FW'(OVER_FRAMES);
  localparam logic [FW-1:0] CNT_MAX  = '1;

  logic          btn_db;
  logic          btn_rise;
  logic [1:0]    state_nxt;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_cnt_nxt;
  logic          lives_gt1;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_raw),
    .btn_db  (btn_db),
    .btn_rise(btn_rise)
  );

`ifdef GAME_CTRL_LIVES_EN
  logic [1:0] lives_q;

  assign lives     = lives_q;
  assign lives_gt1 = (lives_q > 2'd1);

  // Reload lives whenever IDLE is entered or held; lose one per survived hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lives_q <= 2'(LIVES);
    end else if (state_nxt == ST_IDLE) begin
      lives_q <= 2'(LIVES);
    end else if (state == ST_HIT && state_nxt == ST_RUN && lives_gt1) begin
      lives_q <= lives_q - 2'd1;
    end
  end
`else
  // Single life: every hit ends the game
  assign lives     = 2'd1;
  assign lives_gt1 = 1'b0;
`endif

  // Next-state and frame-counter logic; the counter saturates and never wraps
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    case (state)
      ST_IDLE: begin
        frame_cnt_nxt = '0;
        if (btn_rise) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (collision) begin
          state_nxt     = ST_HIT;
          frame_cnt_nxt = '0;
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (frame_cnt == HIT_LAST) begin
            state_nxt     = lives_gt1 ? ST_RUN : ST_OVER;
            frame_cnt_nxt = '0;
          end else if (frame_cnt != CNT_MAX) begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      ST_OVER: begin
        // Saturation is judged on the registered count, so a tick that
        // saturates in the same cycle as the press does not admit it.
        if (btn_rise && frame_cnt >= OVER_SAT) begin
          state_nxt     = ST_IDLE;
          frame_cnt_nxt = '0;
        end else if (frame_tick && frame_cnt < OVER_SAT) begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        frame_cnt_nxt = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      frame_cnt    <= '0;
      scroll_en    <= 1'b0;
      scroll_reset <= 1'b1;
      game_over    <= 1'b0;
      flash        <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_cnt    <= frame_cnt_nxt;
      // Follows btn_db a cycle late in RUN; a collision cuts it off at once
      scroll_en    <= (state == ST_RUN) && !collision && btn_db;
      scroll_reset <= (state_nxt == ST_IDLE);
      game_over    <= (state_nxt == ST_OVER);
      flash        <= (state_nxt == ST_HIT) && frame_cnt_nxt[3];
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: cycle table for start/run/hit, directed OVER/IDLE/reset sequences.
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_game_ctrl;

`ifdef GAME_CTRL_LIVES_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  // Starting lives as seen on the port for this build
  localparam logic [1:0] LV0 = LE ? 2'd2 : 2'd1;

  logic       clk;
  logic       reset_n;
  logic       btn_raw;
  logic       collision;
  logic       frame_tick;
  logic       scroll_en;
  logic       scroll_reset;
  logic [1:0] state;
  logic       game_over;
  logic       flash;
  logic [1:0] lives;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       btn;
    logic       coll;
    logic       ft;
    logic [1:0] st;
    logic       sen;
    logic       srst;
    logic       gov;
    logic [1:0] lv;
  } vec_t;

  vec_t vecs[$];

  game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HIT_FRAMES     (3),
    .OVER_FRAMES    (2),
    .LIVES          (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .collision   (collision),
    .frame_tick  (frame_tick),
    .scroll_en   (scroll_en),
    .scroll_reset(scroll_reset),
    .state       (state),
    .game_over   (game_over),
    .flash       (flash),
    .lives       (lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic sen,
                         input logic srst, input logic gov, input logic fl, input logic [1:0] lv);
    chk({tag, ".state"},        32'(state),        32'(st));
    chk({tag, ".scroll_en"},    32'(scroll_en),    32'(sen));
    chk({tag, ".scroll_reset"}, 32'(scroll_reset), 32'(srst));
    chk({tag, ".game_over"},    32'(game_over),    32'(gov));
    chk({tag, ".flash"},        32'(flash),        32'(fl));
    chk({tag, ".lives"},        32'(lives),        32'(lv));
  endtask

  task automatic add_vec(input logic btn, input logic coll, input logic ft, input logic [1:0] st,
                         input logic sen, input logic srst, input logic gov, input logic [1:0] lv);
    vec_t v;
    v.btn = btn; v.coll = coll; v.ft = ft; v.st = st;
    v.sen = sen; v.srst = srst; v.gov = gov; v.lv = lv;
    vecs.push_back(v);
  endtask

  // Button settles after 2 sync + 4 stable cycles
  task automatic set_btn_settle(input logic v);
    btn_raw = v;
    repeat (6) tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    btn_raw    = 1'b0;
    collision  = 1'b0;
    frame_tick = 1'b0;

    // Press: btn_rise after edge 6, RUN at edge 7, scroll_en at edge 8
    for (int i = 0; i < 6; i++) add_vec(1, 0, 0, 0, 0, 1, 0, LV0);
    add_vec(1, 0, 0, 1, 0, 0, 0, LV0);
    for (int i = 0; i < 3; i++) add_vec(1, 0, 0, 1, 1, 0, 0, LV0);
    // 2-cycle glitches never reach the stability threshold
    add_vec(0, 0, 0, 1, 1, 0, 0, LV0);
    add_vec(0, 0, 0, 1, 1, 0, 0, LV0);
    add_vec(1, 0, 0, 1, 1, 0, 0, LV0);
    add_vec(1, 0, 0, 1, 1, 0, 0, LV0);
    add_vec(0, 0, 0, 1, 1, 0, 0, LV0);
    add_vec(0, 0, 0, 1, 1, 0, 0, LV0);
    for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 1, 1, 0, 0, LV0);
    // One-cycle collision, then three frame ticks in HIT
    add_vec(1, 1, 0, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 0, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 1, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 0, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 1, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 0, 2, 0, 0, 0, LV0);
    add_vec(1, 0, 1, LE ? 2'd1 : 2'd3, 0, 0, LE ? 1'b0 : 1'b1, 2'd1);
    add_vec(1, 0, 0, LE ? 2'd1 : 2'd3, LE, 0, LE ? 1'b0 : 1'b1, 2'd1);

    repeat (2) tick();
    chk_all("reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, LV0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      btn_raw    = vecs[i].btn;
      collision  = vecs[i].coll;
      frame_tick = vecs[i].ft;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sen, vecs[i].srst,
              vecs[i].gov, 1'b0, vecs[i].lv);
    end
    collision  = 1'b0;
    frame_tick = 1'b0;

`ifdef GAME_CTRL_LIVES_EN
    // Second hit with one life left ends the game
    collision = 1'b1;
    tick();
    collision = 1'b0;
    chk_all("hit2", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
`endif
    chk_all("over", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);

    // Press before any OVER frame: ignored
    set_btn_settle(1'b0);
    set_btn_settle(1'b1);
    tick();
    chk("early_press.state", 32'(state), 32'd3);
    set_btn_settle(1'b0);

    // One frame, then press whose rise coincides with the saturating tick: ignored
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    set_btn_settle(1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("same_cycle_sat.state", 32'(state), 32'd3);
    tick();
    chk("same_cycle_sat2.state", 32'(state), 32'd3);

    // Press after saturation: back to IDLE with lives reloaded
    set_btn_settle(1'b0);
    set_btn_settle(1'b1);
    tick();
    chk_all("over_exit", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, LV0);

    // Collision held in IDLE changes nothing
    collision = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle_coll%0d.state", k), 32'(state), 32'd0);
    end
    collision = 1'b0;

    // Start a new game
    set_btn_settle(1'b0);
    set_btn_settle(1'b1);
    tick();
    chk_all("restart", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, LV0);

    // Collision and btn_rise in the same RUN cycle: collision wins
    set_btn_settle(1'b0);
    set_btn_settle(1'b1);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    chk_all("coll_rise", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, LV0);

    // Asynchronous reset mid-HIT, between clock edges
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("pre_rst.state", 32'(state), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, LV0);
    btn_raw = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk_all("post_rst", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, LV0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
